// File: rtl/arb_pkg.sv
// Shared types and default sizing for the asynchronous-request round-robin arbiter.
package arb_pkg;

  localparam int DEF_NUM_REQ  = 4;
  localparam int DEF_MAX_HOLD = 255;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } arb_state_t;

endpackage

// File: rtl/req_sync.sv
// Single-bit two-flop synchronizer bringing one raw request line into the clk domain.
module req_sync (
  input  logic clk,
  input  logic n_rst,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/async_req_arbiter.sv
// Round-robin arbiter for NUM_REQ asynchronous 4-phase requesters with a mandatory release cycle.
// Optional grant watchdog and requester masking are enabled by defining ARB_HOLD_TIMEOUT_EN.
module async_req_arbiter
  import arb_pkg::*;
#(
  parameter int NUM_REQ  = DEF_NUM_REQ,
  parameter int MAX_HOLD = DEF_MAX_HOLD,
  parameter int ID_W     = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic [NUM_REQ-1:0] async_req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    owner_id,
  output logic               busy,
  output logic               grant_pulse,
  output logic               timeout_err
);

  arb_state_t         state_q, state_d;
  logic [NUM_REQ-1:0] sreq, elig;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [ID_W-1:0]    owner_q, owner_d, rr_q, rr_d, winner, idx;
  logic               busy_q, busy_d, pulse_q, pulse_d;
  logic               found, take, drop, owner_req, hold_expired;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_sync
    req_sync u_sync (
      .clk   (clk),
      .n_rst (n_rst),
      .d     (async_req[g]),
      .q     (sreq[g])
    );
  end

  assign owner_req = sreq[owner_q];

`ifdef ARB_HOLD_TIMEOUT_EN
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);

  logic [HOLD_W-1:0]  hold_q;
  logic [NUM_REQ-1:0] mask_q, mask_set;
  logic               force_rel, tmo_q;

  assign hold_expired = (hold_q == HOLD_W'(MAX_HOLD - 1));
  assign force_rel    = (state_q == GRANT) && owner_req && hold_expired;
  assign elig         = sreq & ~mask_q;
  assign timeout_err  = tmo_q;

  always_comb begin
    mask_set = '0;
    if (force_rel) mask_set[owner_q] = 1'b1;
  end

  // A timed-out requester stays masked until its request is seen low once.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      hold_q <= '0;
      mask_q <= '0;
      tmo_q  <= 1'b0;
    end else begin
      if (take)                   hold_q <= '0;
      else if (state_q == GRANT)  hold_q <= hold_q + 1'b1;
      mask_q <= (mask_q | mask_set) & sreq;
      tmo_q  <= force_rel;
    end
  end
`else
  assign hold_expired = 1'b0;
  assign elig         = sreq;
  assign timeout_err  = 1'b0;
`endif

  // Search upward from rr_ptr with wrap; the first eligible requester wins.
  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = ID_W'((int'(rr_q) + i) % NUM_REQ);
      if (!found && elig[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      owner_q <= '0;
      rr_q    <= '0;
      busy_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      busy_q  <= busy_d;
      pulse_q <= pulse_d;
    end
  end

  always_comb begin
    state_d = state_q;
    take    = 1'b0;
    drop    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d = GRANT;
          take    = 1'b1;
        end
      end
      GRANT: begin
        if (!owner_req || hold_expired) begin
          state_d = RELEASE;
          drop    = 1'b1;
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt_d   = gnt_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    busy_d  = busy_q;
    pulse_d = 1'b0;
    if (take) begin
      gnt_d         = '0;
      gnt_d[winner] = 1'b1;
      owner_d       = winner;
      busy_d        = 1'b1;
      pulse_d       = 1'b1;
    end else if (drop) begin
      gnt_d  = '0;
      busy_d = 1'b0;
      rr_d   = ID_W'((int'(owner_q) + 1) % NUM_REQ);
    end else if (state_q != GRANT) begin
      gnt_d  = '0;
      busy_d = 1'b0;
    end
  end

  assign gnt         = gnt_q;
  assign owner_id    = owner_q;
  assign busy        = busy_q;
  assign grant_pulse = pulse_q;

endmodule

// File: tb/tb_async_req_arbiter.sv
// Directed self-checking bench for async_req_arbiter; timeout scenario runs when ARB_HOLD_TIMEOUT_EN is defined.
module tb_async_req_arbiter;

  localparam int N = 4;
`ifdef ARB_HOLD_TIMEOUT_EN
  localparam int MH = 8;
`else
  localparam int MH = 255;
`endif

  logic         clk = 1'b0;
  logic         n_rst;
  logic [N-1:0] async_req;
  logic [N-1:0] gnt;
  logic [1:0]   owner_id;
  logic         busy, grant_pulse, timeout_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  async_req_arbiter #(.NUM_REQ(N), .MAX_HOLD(MH)) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .async_req   (async_req),
    .gnt         (gnt),
    .owner_id    (owner_id),
    .busy        (busy),
    .grant_pulse (grant_pulse),
    .timeout_err (timeout_err)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(input int budget, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (gnt == '0 && n < budget);
  endtask

  task automatic wait_low(input int budget, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (gnt != '0 && n < budget);
  endtask

  task automatic do_reset();
    n_rst     = 1'b0;
    async_req = '0;
    #20;
    @(negedge clk);
    n_rst = 1'b1;
  endtask

  // Wait for a grant to idx, hold it for `hold` cycles, then run the 4-phase release.
  task automatic serve(input int idx, input int hold, input string tag, input int exp_wait);
    int n;
    wait_grant(20, n);
    check({tag, "_wait"}, n, exp_wait);
    check({tag, "_gnt"}, gnt, 32'(1 << idx));
    check({tag, "_owner"}, owner_id, idx);
    check({tag, "_pulse"}, grant_pulse, 1);
    repeat (hold) tick();
    async_req[idx] = 1'b0;
    wait_low(20, n);
    check({tag, "_rel_lat"}, n, 3);
    check({tag, "_busy_low"}, busy, 0);
    async_req[idx] = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;

    // Reset state
    n_rst     = 1'b0;
    async_req = '0;
    #12;
    check("rst_gnt", gnt, 0);
    check("rst_owner", owner_id, 0);
    check("rst_busy", busy, 0);
    check("rst_pulse", grant_pulse, 0);
    check("rst_tmo", timeout_err, 0);
    @(negedge clk);
    n_rst = 1'b1;
    tick();

    // Single request: three-cycle grant latency and three-cycle release latency
    async_req = 4'b0001;
    tick(); tick();
    check("single_early", gnt, 0);
    tick();
    check("single_gnt", gnt, 4'b0001);
    check("single_pulse", grant_pulse, 1);
    check("single_owner", owner_id, 0);
    check("single_busy", busy, 1);
    tick();
    check("single_pulse_off", grant_pulse, 0);
    check("single_hold", gnt, 4'b0001);
    async_req = 4'b0000;
    tick(); tick();
    check("single_rel_early", gnt, 4'b0001);
    tick();
    check("single_rel", gnt, 0);
    check("single_rel_busy", busy, 0);

    // Simultaneous requests: order 0,1,2,3,0 with two idle cycles between grants
    do_reset();
    async_req = 4'b1111;
    serve(0, 5, "rr0", 3);
    serve(1, 5, "rr1", 2);
    serve(2, 5, "rr2", 2);
    serve(3, 5, "rr3", 2);
    serve(0, 5, "rr0b", 2);

    // Fairness between requesters 0 and 2
    do_reset();
    async_req = 4'b0101;
    serve(0, 2, "fair0", 3);
    serve(2, 2, "fair2", 2);
    serve(0, 2, "fair0b", 2);
    serve(2, 2, "fair2b", 2);

    // Reset mid-grant, then requester 1 wins over 2 because rr_ptr returns to 0
    do_reset();
    async_req = 4'b0100;
    wait_grant(20, n);
    check("mid_gnt", gnt, 4'b0100);
    async_req = 4'b0110;
    #2;
    n_rst = 1'b0;
    #1;
    check("mid_rst_gnt", gnt, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_owner", owner_id, 0);
    #20;
    @(negedge clk);
    n_rst = 1'b1;
    wait_grant(20, n);
    check("post_rst_wait", n, 3);
    check("post_rst_gnt", gnt, 4'b0010);
    check("post_rst_owner", owner_id, 1);

    // Glitch: short mid-cycle pulse must never produce more than one grant bit
    do_reset();
    tick();
    #2  async_req[0] = 1'b1;
    #4  async_req[0] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("glitch_onehot", ($countones(gnt) <= 1), 1);
    end
    check("glitch_idle", gnt, 0);

`ifdef ARB_HOLD_TIMEOUT_EN
    // Watchdog: requester 1 holds forever, requester 3 pending
    do_reset();
    async_req = 4'b1010;
    wait_grant(20, n);
    check("tmo_wait", n, 3);
    check("tmo_gnt1", gnt, 4'b0010);
    wait_low(20, n);
    check("tmo_hold_len", n, 8);
    check("tmo_err", timeout_err, 1);
    tick();
    check("tmo_err_off", timeout_err, 0);
    wait_grant(20, n);
    check("tmo_next_wait", n, 1);
    check("tmo_gnt3", gnt, 4'b1000);
    async_req[3] = 1'b0;
    wait_low(20, n);
    check("tmo_rel3", n, 3);
    repeat (10) tick();
    check("tmo_masked", gnt, 0);
    async_req[1] = 1'b0;
    repeat (4) tick();
    async_req[1] = 1'b1;
    wait_grant(20, n);
    check("tmo_regrant", gnt, 4'b0010);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/async_req_arbiter.md
Name: async_req_arbiter

Overview:
- Round-robin arbiter that shares one downstream resource among NUM_REQ requesters, each in an asynchronous clock domain.
- Each requester uses a 4-phase req/gnt handshake.
- Every raw request line passes through a two-flop synchronizer before arbitration.
- Grant is held until the owner's synchronized request falls. A mandatory release cycle separates consecutive grants.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- MAX_HOLD, 255, grant watchdog limit in clk cycles (used only with ARB_HOLD_TIMEOUT_EN).
- ID_W, $clog2(NUM_REQ), width of owner_id.

Ports:
- clk  input  1  system clock
- n_rst  input  1  asynchronous active-low reset
- async_req  input  NUM_REQ  raw request lines, asynchronous to clk; bit i = requester i
- gnt  output  NUM_REQ  registered one-hot grant (all-zero when idle)
- owner_id  output  ID_W  index of current owner; valid while busy=1
- busy  output  1  resource currently granted
- grant_pulse  output  1  one-cycle strobe in the cycle gnt first asserts
- timeout_err  output  1  one-cycle strobe on watchdog release (tied 0 without the macro)

Behaviour:
- Interface: reset n_rst, asynchronous, active-low; clock clk.
- Reset values:
  - gnt=0, owner_id=0, busy=0, grant_pulse=0, timeout_err=0.
  - Synchronizer flops reset to 0.
  - rr_ptr=0; state=IDLE.
- Synchronization: sreq[i] = async_req[i] delayed by two flops. All arbitration uses sreq only.
- State machine (states IDLE, GRANT, RELEASE):
  - IDLE: if any eligible sreq, pick the first set bit searching upward from rr_ptr with wrap (rr_ptr, rr_ptr+1, ..., NUM_REQ-1, 0, ...).
    - Next edge: gnt[winner]=1, owner_id=winner, busy=1, grant_pulse=1; go to GRANT.
    - If no eligible sreq, stay in IDLE.
  - GRANT: hold gnt while sreq[owner]=1. Requests arriving from other requesters do not preempt.
    - When sreq[owner]=0, next edge: gnt=0, busy=0, rr_ptr=(owner+1) mod NUM_REQ; go to RELEASE.
  - RELEASE: exactly one cycle with gnt=0; then go to IDLE. The requester sees gnt drop before any new grant.
- Latency: async_req rising, setup-met before edge E1 -> sreq high after E2 -> gnt high after E3 (3 cycles, idle arbiter).
- Owner req fall (sampled at E1) -> gnt low after E3.
- Minimum turnaround: two cycles of gnt=0 between any two grants (the release edge plus the RELEASE state).
- Simultaneous requests: the round-robin order above decides. After reset, requester 0 has top priority.
- Request pulse shorter than one clk period may be missed; requesters must hold req until gnt is seen (4-phase rule).
- Request dropped by its owner before gnt arrives: the grant is still issued, then released normally once sreq=0 is observed.
- Reset mid-grant: gnt drops asynchronously, and the FSM and pointer return to their reset values.
- Exactly one gnt bit may be high at any time (one-hot or zero is an invariant).

Optional Feature:
- Macro: ARB_HOLD_TIMEOUT_EN.
- Defined:
  - A hold counter clears on each grant and increments every cycle in GRANT.
  - When the counter reaches MAX_HOLD, release is forced: same release path as a normal release, and timeout_err pulses for 1 cycle.
  - The offending requester is masked (ineligible) until its sreq is observed low, then unmasked.
- Undefined: no counter and no mask logic; timeout_err is tied to 0; a grant may be held indefinitely.

Decomposition:
- Package arb_pkg holds:
  - state enum arb_state_t {IDLE, GRANT, RELEASE}, 2-bit encoding;
  - constants for the default NUM_REQ and MAX_HOLD.
- Sub-module req_sync: a single-bit two-flop synchronizer with reset value 0, instantiated NUM_REQ times via generate.
- Round-robin search and FSM stay in the top module.

Test Plan:
- Single request: async_req=0001, held -> gnt=0001 three cycles later, grant_pulse=1 for 1 cycle, owner_id=0. Drop req -> gnt=0000 three cycles later.
- Simultaneous requests: async_req=1111 held, each owner dropping 5 cycles after its grant -> grant order 0,1,2,3,0 with two gnt-low cycles between grants.
- Fairness: requesters 0 and 2 both request repeatedly -> grants alternate 0,2,0,2; requester 0 never wins twice in a row while 2 is pending.
- Reset mid-grant: gnt=0100, assert n_rst=0 -> gnt=0000 and busy=0 immediately. After release with req 1 and 2 pending -> requester 1 granted first (rr_ptr=0).
- Timeout (macro on, MAX_HOLD=8): requester 1 holds req forever with requester 3 pending -> gnt[1] drops after 8 cycles in GRANT and timeout_err pulses. Requester 3 is granted next; requester 1 is not regranted until its req drops and reasserts.
- Glitch: async_req bit 0 pulses high for 0.4 of a clk period, mid-cycle -> gnt either stays 0 or completes one clean grant/release; gnt never shows multiple bits set.
